// File: rtl/fetch_pc_pkg.sv
// Shared types and constants for the fetch PC controller.
package fetch_pc_pkg;

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        WAIT    = 2'd1,
        DISCARD = 2'd2,
        HALT    = 2'd3
    } fetch_state_e;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        TRAP = 2'd1,
        EX   = 2'd2,
        ID   = 2'd3
    } redir_src_e;

    localparam int PC_STEP    = 4;
    localparam int STAT_WIDTH = 32;

    function automatic logic [STAT_WIDTH-1:0] sat_inc(input logic [STAT_WIDTH-1:0] v);
        return (&v) ? v : v + STAT_WIDTH'(1);
    endfunction

endpackage

// File: rtl/fetch_pc_ctrl_if.sv
// Instruction-memory fetch port between fetch_pc_ctrl (master) and memory (slave).
// Handshake: a request is accepted in a cycle with imem_req_o && imem_gnt_i; its
// response is a single imem_rvalid_i cycle carrying imem_rdata_i, with no back-pressure.
interface fetch_pc_ctrl_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  imem_req_o;
    logic [DATA_WIDTH-1:0] imem_addr_o;
    logic                  imem_gnt_i;
    logic                  imem_rvalid_i;
    logic [DATA_WIDTH-1:0] imem_rdata_i;

    modport master (
        output imem_req_o, imem_addr_o,
        input  imem_gnt_i, imem_rvalid_i, imem_rdata_i
    );

    modport slave (
        input  imem_req_o, imem_addr_o,
        output imem_gnt_i, imem_rvalid_i, imem_rdata_i
    );
endinterface

// File: rtl/fetch_skid_buffer.sv
// One-entry {pc, instr} holding register; clear beats load, load beats drain.
module fetch_skid_buffer #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_i,
    input  logic                  drain_i,
    input  logic                  clear_i,
    input  logic [DATA_WIDTH-1:0] pc_i,
    input  logic [DATA_WIDTH-1:0] instr_i,
    output logic                  valid_o,
    output logic [DATA_WIDTH-1:0] pc_o,
    output logic [DATA_WIDTH-1:0] instr_o
);
    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic [DATA_WIDTH-1:0] instr_q, instr_d;

    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        if (clear_i) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            valid_d = 1'b1;
            pc_d    = pc_i;
            instr_d = instr_i;
        end else if (drain_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            instr_q <= '0;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    assign valid_o = valid_q;
    assign pc_o    = pc_q;
    assign instr_o = instr_q;
endmodule

// File: rtl/fetch_pc_ctrl.sv
// PC sequencer and fetch-port controller with redirect arbitration and stall skid buffer.
// Define FETCH_PC_CTRL_STATS_EN to add saturating redirect/discard/stall counters.
module fetch_pc_ctrl
    import fetch_pc_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0,
    parameter logic [DATA_WIDTH-1:0] PC_LIMIT   = 'h1000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall_i,
    input  logic                  trap_i,
    input  logic [DATA_WIDTH-1:0] trap_vec_i,
    input  logic                  ex_redirect_i,
    input  logic [DATA_WIDTH-1:0] ex_target_i,
    input  logic                  id_jump_i,
    input  logic [DATA_WIDTH-1:0] id_target_i,
    fetch_pc_ctrl_if.master       imem,
    output logic                  if_valid_o,
    output logic [DATA_WIDTH-1:0] if_pc_o,
    output logic [DATA_WIDTH-1:0] if_instr_o,
    output logic                  flush_o,
    output logic                  halt_o,
    output logic [DATA_WIDTH-1:0] pc_o,
    output fetch_state_e          state_o
`ifdef FETCH_PC_CTRL_STATS_EN
    ,
    output logic [STAT_WIDTH-1:0] stat_redirects_o,
    output logic [STAT_WIDTH-1:0] stat_discards_o,
    output logic [STAT_WIDTH-1:0] stat_stall_cycles_o
`endif
);
    fetch_state_e          state_q, state_d;
    logic [DATA_WIDTH-1:0] pc_q, pc_d, fetch_pc_q, fetch_pc_d;
    logic                  if_valid_q, if_valid_d, flush_q, flush_d, halt_q, halt_d;
    logic [DATA_WIDTH-1:0] if_pc_q, if_pc_d, if_instr_q, if_instr_d;

    redir_src_e            redir_src;
    logic [DATA_WIDTH-1:0] redir_target, pc_inc;
    logic                  imem_req, resp_drop;
    logic                  skid_load, skid_drain, skid_clear, skid_valid;
    logic [DATA_WIDTH-1:0] skid_pc, skid_instr;

    function automatic logic pc_ok(input logic [DATA_WIDTH-1:0] a);
        return (a <= PC_LIMIT) && (a[1:0] == 2'b00);
    endfunction

    assign pc_inc   = pc_q + DATA_WIDTH'(PC_STEP);
    assign imem_req = (state_q == FETCH) && !skid_valid && !rst;

    // Once halt is pending no redirect may revive the fetch stream.
    always_comb begin
        redir_src    = NONE;
        redir_target = '0;
        if (state_q != HALT && !halt_q) begin
            if (trap_i) begin
                redir_src    = TRAP;
                redir_target = trap_vec_i;
            end else if (ex_redirect_i) begin
                redir_src    = EX;
                redir_target = ex_target_i;
            end else if (id_jump_i) begin
                redir_src    = ID;
                redir_target = id_target_i;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        fetch_pc_d = fetch_pc_q;
        if_valid_d = if_valid_q;
        if_pc_d    = if_pc_q;
        if_instr_d = if_instr_q;
        flush_d    = 1'b0;
        halt_d     = halt_q;
        skid_load  = 1'b0;
        skid_drain = 1'b0;
        skid_clear = 1'b0;
        resp_drop  = 1'b0;

        if (!stall_i) begin
            if (skid_valid) begin
                if_valid_d = 1'b1;
                if_pc_d    = skid_pc;
                if_instr_d = skid_instr;
                skid_drain = 1'b1;
            end else begin
                if_valid_d = 1'b0;
            end
        end

        case (state_q)
            FETCH: begin
                if (imem_req && imem.imem_gnt_i) begin
                    fetch_pc_d = pc_q;
                    state_d    = WAIT;
                    if (pc_ok(pc_inc)) pc_d = pc_inc;
                    else               halt_d = 1'b1;
                end
            end
            WAIT: begin
                if (imem.imem_rvalid_i) begin
                    if (!stall_i || !if_valid_q) begin
                        if_valid_d = 1'b1;
                        if_pc_d    = fetch_pc_q;
                        if_instr_d = imem.imem_rdata_i;
                    end else begin
                        skid_load = 1'b1;
                    end
                    state_d = halt_q ? HALT : FETCH;
                end
            end
            DISCARD: begin
                if (imem.imem_rvalid_i) begin
                    resp_drop = 1'b1;
                    state_d   = FETCH;
                end
            end
            default: ;
        endcase

        // A redirect discards everything younger and decides the next state itself.
        if (redir_src != NONE) begin
            flush_d    = 1'b1;
            if_valid_d = 1'b0;
            skid_clear = 1'b1;
            skid_load  = 1'b0;
            halt_d     = halt_q;
            pc_d       = pc_q;
            if (state_q == WAIT && imem.imem_rvalid_i) resp_drop = 1'b1;
            if (!pc_ok(redir_target)) begin
                halt_d  = 1'b1;
                state_d = HALT;
            end else begin
                pc_d = redir_target;
                case (state_q)
                    FETCH:   state_d = (imem_req && imem.imem_gnt_i) ? DISCARD : FETCH;
                    WAIT,
                    DISCARD: state_d = imem.imem_rvalid_i ? FETCH : DISCARD;
                    default: state_d = state_q;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= FETCH;
            pc_q       <= RESET_PC;
            fetch_pc_q <= '0;
            if_valid_q <= 1'b0;
            if_pc_q    <= '0;
            if_instr_q <= '0;
            flush_q    <= 1'b0;
            halt_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            fetch_pc_q <= fetch_pc_d;
            if_valid_q <= if_valid_d;
            if_pc_q    <= if_pc_d;
            if_instr_q <= if_instr_d;
            flush_q    <= flush_d;
            halt_q     <= halt_d;
        end
    end

    fetch_skid_buffer #(.DATA_WIDTH(DATA_WIDTH)) u_skid (
        .clk     (clk),
        .rst     (rst),
        .load_i  (skid_load),
        .drain_i (skid_drain),
        .clear_i (skid_clear),
        .pc_i    (fetch_pc_q),
        .instr_i (imem.imem_rdata_i),
        .valid_o (skid_valid),
        .pc_o    (skid_pc),
        .instr_o (skid_instr)
    );

    assign imem.imem_req_o  = imem_req;
    assign imem.imem_addr_o = pc_q;
    assign if_valid_o       = if_valid_q;
    assign if_pc_o          = if_pc_q;
    assign if_instr_o       = if_instr_q;
    assign flush_o          = flush_q;
    assign halt_o           = halt_q;
    assign pc_o             = pc_q;
    assign state_o          = state_q;

`ifdef FETCH_PC_CTRL_STATS_EN
    logic [STAT_WIDTH-1:0] stat_redir_q, stat_redir_d;
    logic [STAT_WIDTH-1:0] stat_disc_q, stat_disc_d;
    logic [STAT_WIDTH-1:0] stat_stall_q, stat_stall_d;

    always_comb begin
        stat_redir_d = stat_redir_q;
        stat_disc_d  = stat_disc_q;
        stat_stall_d = stat_stall_q;
        if (redir_src != NONE)     stat_redir_d = sat_inc(stat_redir_q);
        if (resp_drop)             stat_disc_d  = sat_inc(stat_disc_q);
        if (stall_i && if_valid_q) stat_stall_d = sat_inc(stat_stall_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_redir_q <= '0;
            stat_disc_q  <= '0;
            stat_stall_q <= '0;
        end else begin
            stat_redir_q <= stat_redir_d;
            stat_disc_q  <= stat_disc_d;
            stat_stall_q <= stat_stall_d;
        end
    end

    assign stat_redirects_o    = stat_redir_q;
    assign stat_discards_o     = stat_disc_q;
    assign stat_stall_cycles_o = stat_stall_q;
`else
    logic unused_drop;
    assign unused_drop = resp_drop;
`endif
endmodule
